// File: rtl/reg_bank_dump.sv
// 16x16 register bank with two async read ports and a valid/ready dump streamer (R0 first).
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum word to each dump.
module reg_bank_dump #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Wr_En,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [WIDTH-1:0]  Wr_Data,
  input  logic [ADDR_W-1:0] Rd_Addr_A,
  output logic [WIDTH-1:0]  Rd_Data_A,
  input  logic [ADDR_W-1:0] Rd_Addr_B,
  output logic [WIDTH-1:0]  Rd_Data_B,
  input  logic              Dump_Start,
  input  logic              Dump_Ready,
  output logic              Dump_Valid,
  output logic [WIDTH-1:0]  Dump_Data,
  output logic              Dump_Busy,
  output logic              Dump_Done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
`ifdef REG_DUMP_CHECKSUM_EN
    CSUM = 2'd3,
`endif
    DONE = 2'd2
  } state_t;

  state_t                        state, state_nxt;
  logic [DEPTH-1:0][WIDTH-1:0]   bank;
  logic [ADDR_W-1:0]             idx, idx_inc;
  logic [WIDTH-1:0]              data_q;
  logic                          accept;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [WIDTH-1:0]              csum;
`endif

  assign Rd_Data_A = bank[Rd_Addr_A];
  assign Rd_Data_B = bank[Rd_Addr_B];
  assign Dump_Data = data_q;
  assign accept    = Dump_Valid & Dump_Ready;
  assign idx_inc   = idx + 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) bank <= '0;
    else if (Wr_En) bank[Wr_Addr] <= Wr_Data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    Dump_Valid = 1'b0;
    Dump_Busy  = 1'b0;
    Dump_Done  = 1'b0;
    case (state)
      IDLE: if (Dump_Start) state_nxt = SEND;
      SEND: begin
        Dump_Valid = 1'b1;
        Dump_Busy  = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        if (Dump_Ready && idx == LAST) state_nxt = CSUM;
`else
        if (Dump_Ready && idx == LAST) state_nxt = DONE;
`endif
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        Dump_Valid = 1'b1;
        Dump_Busy  = 1'b1;
        if (Dump_Ready) state_nxt = DONE;
      end
`endif
      DONE: begin
        Dump_Done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // data_q only loads on start or accept, so writes never disturb a presented word
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx    <= '0;
      data_q <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum   <= '0;
`endif
    end else if (state == IDLE) begin
      if (Dump_Start) begin
        idx    <= '0;
        data_q <= bank[0];
`ifdef REG_DUMP_CHECKSUM_EN
        csum   <= '0;
`endif
      end
    end else if (state == SEND && accept) begin
`ifdef REG_DUMP_CHECKSUM_EN
      csum <= csum ^ data_q;
`endif
      if (idx == LAST) begin
`ifdef REG_DUMP_CHECKSUM_EN
        data_q <= csum ^ data_q;
`endif
      end else begin
        idx    <= idx_inc;
        data_q <= bank[idx_inc];
      end
    end
  end
endmodule

// File: tb/tb_reg_bank_dump.sv
// Scoreboard bench for reg_bank_dump: expected dump words queued at stimulus, popped on accept.
module tb_reg_bank_dump;
  logic        Clk, Reset, Wr_En, Dump_Start, Dump_Ready;
  logic [3:0]  Wr_Addr, Rd_Addr_A, Rd_Addr_B;
  logic [15:0] Wr_Data, Rd_Data_A, Rd_Data_B, Dump_Data;
  logic        Dump_Valid, Dump_Busy, Dump_Done;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e, x;

  reg_bank_dump dut (
    .Clk(Clk), .Reset(Reset), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Rd_Addr_A(Rd_Addr_A), .Rd_Data_A(Rd_Data_A), .Rd_Addr_B(Rd_Addr_B), .Rd_Data_B(Rd_Data_B),
    .Dump_Start(Dump_Start), .Dump_Ready(Dump_Ready), .Dump_Valid(Dump_Valid),
    .Dump_Data(Dump_Data), .Dump_Busy(Dump_Busy), .Dump_Done(Dump_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // all drivers are entered and left at posedge+1
  task automatic wr(input int a, input logic [15:0] d);
    Wr_En = 1'b1; Wr_Addr = 4'(a); Wr_Data = d;
    @(posedge Clk); #1;
    Wr_En = 1'b0;
  endtask

  task automatic start_dump();
    Dump_Start = 1'b1;
    @(posedge Clk); #1;
    Dump_Start = 1'b0;
  endtask

  task automatic push_csum();
`ifdef REG_DUMP_CHECKSUM_EN
    x = '0;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`endif
  endtask

  task automatic test_reset();
    wr(2, 16'h1234);
    Rd_Addr_A = 4'd2; Rd_Addr_B = 4'd2; Dump_Ready = 1'b0;
    start_dump();
    Reset = 1'b1; #2;
    total++; if (Rd_Data_A !== 16'h0) begin bad++; $display("FAIL rst_rda: got %h exp 0000", Rd_Data_A); end
    total++; if (Rd_Data_B !== 16'h0) begin bad++; $display("FAIL rst_rdb: got %h exp 0000", Rd_Data_B); end
    total++; if (Dump_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", Dump_Valid); end
    total++; if (Dump_Busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b exp 0", Dump_Busy); end
    total++; if (Dump_Done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b exp 0", Dump_Done); end
    total++; if (Dump_Data !== 16'h0) begin bad++; $display("FAIL rst_data: got %h exp 0000", Dump_Data); end
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_write_read();
    Wr_En = 1'b1; Wr_Addr = 4'd3; Wr_Data = 16'hBEEF; Rd_Addr_A = 4'd3; Rd_Addr_B = 4'd4;
    #2;
    total++; if (Rd_Data_A !== 16'h0) begin bad++; $display("FAIL no_bypass: got %h exp 0000", Rd_Data_A); end
    @(posedge Clk); #1;
    Wr_En = 1'b0;
    total++; if (Rd_Data_A !== 16'hBEEF) begin bad++; $display("FAIL wr_rda: got %h exp beef", Rd_Data_A); end
    total++; if (Rd_Data_B !== 16'h0) begin bad++; $display("FAIL wr_rdb: got %h exp 0000", Rd_Data_B); end
  endtask

  task automatic test_full_dump();
    int cyc;
    for (int k = 0; k < 16; k++) wr(k, 16'h1000 + 16'(k));
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(16'h1000 + 16'(k));
    push_csum();
    Dump_Ready = 1'b1; Dump_Start = 1'b1;
    @(negedge Clk);
    total++; if (Dump_Valid !== 1'b0) begin bad++; $display("FAIL lat_early: got %b exp 0", Dump_Valid); end
    @(posedge Clk); #1; Dump_Start = 1'b0;
    @(negedge Clk);
    total++; if (Dump_Valid !== 1'b1 || Dump_Busy !== 1'b1) begin bad++; $display("FAIL lat_valid: got v=%b b=%b exp 1 1", Dump_Valid, Dump_Busy); end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 64) begin
      total++;
      if (!Dump_Valid) begin bad++; $display("FAIL full_gap: got valid 0 exp 1 at cycle %0d", cyc); end
      else begin
        e = exp_q.pop_front();
        if (Dump_Data !== e) begin bad++; $display("FAIL full_word: got %h exp %h", Dump_Data, e); end
      end
      @(posedge Clk); #1; @(negedge Clk); cyc++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_timeout: got %0d left exp 0", exp_q.size()); end
    total++; if (Dump_Done !== 1'b1 || Dump_Valid !== 1'b0 || Dump_Busy !== 1'b0)
      begin bad++; $display("FAIL full_done: got d=%b v=%b b=%b exp 1 0 0", Dump_Done, Dump_Valid, Dump_Busy); end
    @(negedge Clk);
    total++; if (Dump_Done !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b exp 0", Dump_Done); end
    @(posedge Clk); #1;
  endtask

  task automatic test_stall();
    int cyc, n, h;
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(k == 6 ? 16'h7777 : 16'h1000 + 16'(k));
    push_csum();
    Dump_Ready = 1'b1;
    start_dump();
    @(negedge Clk);
    cyc = 0; n = 0; h = 0;
    while (exp_q.size() != 0 && cyc < 64) begin
      if (Dump_Valid && Dump_Ready) begin
        total++; e = exp_q.pop_front(); n++;
        if (Dump_Data !== e) begin bad++; $display("FAIL stall_word: got %h exp %h", Dump_Data, e); end
      end else if (!Dump_Ready) begin
        total++;
        if (Dump_Data !== 16'h1005 || Dump_Valid !== 1'b1)
          begin bad++; $display("FAIL stall_hold: got %h v=%b exp 1005 1", Dump_Data, Dump_Valid); end
      end
      @(posedge Clk); #1;
      if (!Dump_Ready) begin
        case (h)
          0: begin Wr_En = 1'b1; Wr_Addr = 4'd5; Wr_Data = 16'hFFFF; end
          1: begin Wr_Addr = 4'd6; Wr_Data = 16'h7777; Dump_Start = 1'b1; end
          default: begin Wr_En = 1'b0; Dump_Start = 1'b0; Dump_Ready = 1'b1; end
        endcase
        h++;
      end else if (n == 5 && h == 0) Dump_Ready = 1'b0;
      @(negedge Clk); cyc++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_timeout: got %0d left exp 0", exp_q.size()); end
    total++; if (Dump_Done !== 1'b1) begin bad++; $display("FAIL stall_done: got %b exp 1", Dump_Done); end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc, n;
    for (int k = 0; k < 16; k++) wr(k, 16'h1000 + 16'(k));
    Dump_Ready = 1'b1;
    start_dump();
    @(negedge Clk);
    n = 0; cyc = 0;
    while (n < 7 && cyc < 64) begin
      if (Dump_Valid) n++;
      @(posedge Clk); #1; @(negedge Clk); cyc++;
    end
    Dump_Ready = 1'b0;
    total++; if (Dump_Data !== 16'h1007) begin bad++; $display("FAIL mid_word7: got %h exp 1007", Dump_Data); end
    @(posedge Clk); #1;
    Reset = 1'b1; #1;
    total++; if (Dump_Valid !== 1'b0 || Dump_Busy !== 1'b0 || Dump_Data !== 16'h0)
      begin bad++; $display("FAIL mid_reset: got v=%b b=%b d=%h exp 0 0 0000", Dump_Valid, Dump_Busy, Dump_Data); end
    @(posedge Clk); #1; Reset = 1'b0;
    start_dump();
    @(negedge Clk);
    total++; if (Dump_Valid !== 1'b1 || Dump_Data !== 16'h0)
      begin bad++; $display("FAIL restart_r0: got v=%b d=%h exp 1 0000", Dump_Valid, Dump_Data); end
    Dump_Ready = 1'b1;
    cyc = 0;
    while (Dump_Done !== 1'b1 && cyc < 64) begin @(posedge Clk); #1; @(negedge Clk); cyc++; end
    total++; if (Dump_Done !== 1'b1) begin bad++; $display("FAIL restart_done: got %b exp 1", Dump_Done); end
    @(posedge Clk); #1;
  endtask

  task automatic test_checksum();
    int cyc, n;
    wr(0, 16'hA5A5);
    exp_q.delete();
    exp_q.push_back(16'hA5A5);
    for (int k = 1; k < 16; k++) exp_q.push_back(16'h0);
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back(16'hA5A5);
`endif
    Dump_Ready = 1'b1;
    start_dump();
    @(negedge Clk);
    cyc = 0; n = 0;
    while (Dump_Valid && cyc < 64) begin
      total++; n++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL cs_extra: got %h exp none", Dump_Data); end
      else begin
        e = exp_q.pop_front();
        if (Dump_Data !== e) begin bad++; $display("FAIL cs_word: got %h exp %h", Dump_Data, e); end
      end
      @(posedge Clk); #1; @(negedge Clk); cyc++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cs_count: got %0d words exp %0d", n, n + exp_q.size()); end
    total++; if (Dump_Done !== 1'b1) begin bad++; $display("FAIL cs_done: got %b exp 1", Dump_Done); end
    @(posedge Clk); #1;
  endtask

  initial begin
    Reset = 1'b1; Wr_En = 1'b0; Wr_Addr = '0; Wr_Data = '0; Rd_Addr_A = '0; Rd_Addr_B = '0;
    Dump_Start = 1'b0; Dump_Ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    test_reset();
    test_write_read();
    test_full_dump();
    test_stall();
    test_reset_mid();
    test_checksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
